// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an auto-scan mode that walks the first
// SCAN_LEN outputs, DWELL cycles each; en=0 blanks the outputs and freezes scan state.
module scan_decoder #(
  parameter int SEL_W      = 4,
  parameter int SCAN_LEN   = 2**SEL_W,
  parameter int DWELL      = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               hold,
  input  logic [SEL_W-1:0]   sel_in,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]   sel_out,
  output logic               step,
  output logic               wrap
);
  localparam int N    = 2**SEL_W;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(SCAN_LEN - 1);
  localparam logic [N-1:0]     OUT_IDLE   = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] s);
    logic [N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  logic [SEL_W-1:0] idx_q, idx_d, idx_next;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [N-1:0]     out_q, out_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    out_d    = OUT_IDLE;
    sel_d    = sel_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    if (en) begin
      if (!mode) begin
        // Direct mode parks the scan so the next scan entry starts fresh at index 0.
        idx_d   = '0;
        dwell_d = '0;
        out_d   = decode(sel_in);
        sel_d   = sel_in;
      end else if (hold || (dwell_q != DWELL_LAST)) begin
        if (!hold) dwell_d = dwell_q + 1'b1;
        out_d = decode(idx_q);
        sel_d = idx_q;
      end else begin
        dwell_d = '0;
        idx_d   = idx_next;
        out_d   = decode(idx_next);
        sel_d   = idx_next;
        step_d  = 1'b1;
        wrap_d  = (idx_next == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      dwell_q <= '0;
      out_q   <= OUT_IDLE;
      sel_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out     = out_q;
  assign sel_out = sel_q;
  assign step    = step_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: main (16 outputs, dwell 3), short-scan corner (len 5, dwell 1)
// and one-cold corner, all sharing one set of inputs.
module tb_scan_decoder;
  logic clk = 1'b0;
  logic rst, en, mode, hold;
  logic [3:0] sel_in;

  logic [15:0] out, out_c, out_al;
  logic [3:0]  sel_out, sel_c, sel_al;
  logic        step, wrap, step_c, wrap_c, step_al, wrap_al;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: k counts enabled, unheld scan edges since scan start.
  int          k_m, k_c;
  logic [15:0] e_out, c_out;
  logic [3:0]  e_sel, c_sel;
  logic        e_step, e_wrap, c_step, c_wrap;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(4), .SCAN_LEN(16), .DWELL(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hold(hold), .sel_in(sel_in),
    .out(out), .sel_out(sel_out), .step(step), .wrap(wrap));

  scan_decoder #(.SEL_W(4), .SCAN_LEN(5), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hold(hold), .sel_in(sel_in),
    .out(out_c), .sel_out(sel_c), .step(step_c), .wrap(wrap_c));

  scan_decoder #(.SEL_W(4), .SCAN_LEN(16), .DWELL(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hold(hold), .sel_in(sel_in),
    .out(out_al), .sel_out(sel_al), .step(step_al), .wrap(wrap_al));

  task automatic model_reset();
    k_m = 0; k_c = 0;
    e_out = 16'h0; c_out = 16'h0;
    e_sel = 4'd0;  c_sel = 4'd0;
    e_step = 1'b0; e_wrap = 1'b0; c_step = 1'b0; c_wrap = 1'b0;
  endtask

  // One rising edge: update the reference from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    e_step = 1'b0; e_wrap = 1'b0; c_step = 1'b0; c_wrap = 1'b0;
    if (!en) begin
      e_out = 16'h0; c_out = 16'h0;
    end else if (!mode) begin
      k_m = 0; k_c = 0;
      e_sel = sel_in; c_sel = sel_in;
      e_out = 16'd1 << sel_in; c_out = 16'd1 << sel_in;
    end else begin
      if (!hold) begin
        k_m++; k_c++;
        e_step = (k_m % 3 == 0);
        c_step = 1'b1;
      end
      e_sel = 4'((k_m / 3) % 16);
      c_sel = 4'(k_c % 5);
      e_wrap = e_step && (e_sel == 4'd0);
      c_wrap = c_step && (c_sel == 4'd0);
      e_out = 16'd1 << e_sel;
      c_out = 16'd1 << c_sel;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; hold = 1'b0; sel_in = 4'd0;
    model_reset();
    #3;
    n_vec++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out: got %h want 0000", out); end
    n_vec++; if (sel_out !== 4'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel_out); end
    n_vec++; if ({step, wrap} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {step, wrap}); end
    n_vec++; if (out_al !== 16'hFFFF) begin n_err++; $display("FAIL reset_out_al: got %h want ffff", out_al); end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 16; s++) begin
      sel_in = 4'(s);
      tick();
      n_vec++; if (out !== (16'd1 << s)) begin n_err++; $display("FAIL direct_out: sel %0d got %h want %h", s, out, 16'd1 << s); end
      n_vec++; if (sel_out !== 4'(s)) begin n_err++; $display("FAIL direct_sel: got %0d want %0d", sel_out, s); end
      n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL direct_step: got %b want 0", step); end
      n_vec++; if (out_c !== (16'd1 << s)) begin n_err++; $display("FAIL direct_out_c: got %h want %h", out_c, 16'd1 << s); end
    end
  endtask

  task automatic test_scan_sweep();
    int nsteps;
    int nwrap_c;
    do_reset();
    en = 1'b1; mode = 1'b1; hold = 1'b0;
    nsteps = 0; nwrap_c = 0;
    for (int c = 1; c <= 48; c++) begin
      tick();
      nsteps += int'(step);
      nwrap_c += int'(wrap_c);
      n_vec++; if (out !== e_out) begin n_err++; $display("FAIL sweep_out: cyc %0d got %h want %h", c, out, e_out); end
      n_vec++; if (wrap !== (c == 48)) begin n_err++; $display("FAIL sweep_wrap: cyc %0d got %b want %b", c, wrap, c == 48); end
      n_vec++; if (out_c !== (16'd1 << (c % 5))) begin n_err++; $display("FAIL corner_out: cyc %0d got %h want %h", c, out_c, 16'd1 << (c % 5)); end
      n_vec++; if ({step_c, wrap_c} !== {1'b1, c % 5 == 0}) begin n_err++; $display("FAIL corner_pulse: cyc %0d got %b%b", c, step_c, wrap_c); end
      n_vec++; if (out_al !== ~e_out) begin n_err++; $display("FAIL sweep_out_al: got %h want %h", out_al, ~e_out); end
    end
    n_vec++; if (out !== 16'h0001) begin n_err++; $display("FAIL sweep_end: got %h want 0001", out); end
    n_vec++; if (nsteps !== 16) begin n_err++; $display("FAIL sweep_steps: got %0d want 16", nsteps); end
    n_vec++; if (nwrap_c !== 9) begin n_err++; $display("FAIL corner_wraps: got %0d want 9", nwrap_c); end
  endtask

  task automatic test_hold_disable();
    // 16 more scan edges lands on index 5 with one dwell cycle spent.
    for (int i = 0; i < 16; i++) tick();
    n_vec++; if (out !== 16'h0020) begin n_err++; $display("FAIL hold_pre: got %h want 0020", out); end
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if ({out, step} !== {16'h0020, 1'b0}) begin n_err++; $display("FAIL hold_out: got %h/%b want 0020/0", out, step); end
    end
    hold = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if ({out, sel_out, step} !== {16'h0000, 4'd5, 1'b0}) begin n_err++; $display("FAIL disable: got %h/%0d/%b want 0000/5/0", out, sel_out, step); end
    end
    en = 1'b1;
    tick();
    n_vec++; if ({out, step} !== {16'h0020, 1'b0}) begin n_err++; $display("FAIL reenable: got %h/%b want 0020/0", out, step); end
    tick();
    n_vec++; if ({out, step} !== {16'h0040, 1'b1}) begin n_err++; $display("FAIL reenable_adv: got %h/%b want 0040/1", out, step); end
  endtask

  task automatic test_mode_switch();
    for (int i = 0; i < 9; i++) tick();
    n_vec++; if (out !== 16'h0200) begin n_err++; $display("FAIL switch_pre: got %h want 0200", out); end
    mode = 1'b0; sel_in = 4'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if ({out, sel_out, step} !== {16'h0004, 4'd2, 1'b0}) begin n_err++; $display("FAIL switch_direct: got %h/%0d/%b want 0004/2/0", out, sel_out, step); end
    end
    mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if ({out, step} !== {16'h0001, 1'b0}) begin n_err++; $display("FAIL switch_restart: got %h/%b want 0001/0", out, step); end
    end
    tick();
    n_vec++; if ({out, step} !== {16'h0002, 1'b1}) begin n_err++; $display("FAIL switch_adv: got %h/%b want 0002/1", out, step); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 18; i++) tick();
    n_vec++; if (out !== 16'h0080) begin n_err++; $display("FAIL areset_pre: got %h want 0080", out); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++; if ({out, sel_out} !== {16'h0000, 4'd0}) begin n_err++; $display("FAIL areset_now: got %h/%0d want 0000/0", out, sel_out); end
    n_vec++; if (out_al !== 16'hFFFF) begin n_err++; $display("FAIL areset_al: got %h want ffff", out_al); end
    #1;
    rst = 1'b0;
    tick();
    n_vec++; if ({out, sel_out} !== {16'h0001, 4'd0}) begin n_err++; $display("FAIL areset_resume: got %h/%0d want 0001/0", out, sel_out); end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; mode = 1'b1; hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en     = ($urandom_range(0, 9) != 0);
      hold   = ($urandom_range(0, 7) == 0);
      sel_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      tick();
      n_vec++; if ({out, sel_out, step, wrap} !== {e_out, e_sel, e_step, e_wrap}) begin
        n_err++; $display("FAIL rand_main: cyc %0d got %h/%0d/%b%b want %h/%0d/%b%b", c, out, sel_out, step, wrap, e_out, e_sel, e_step, e_wrap);
      end
      n_vec++; if ({out_c, sel_c, step_c, wrap_c} !== {c_out, c_sel, c_step, c_wrap}) begin
        n_err++; $display("FAIL rand_corner: cyc %0d got %h/%0d/%b%b want %h/%0d/%b%b", c, out_c, sel_c, step_c, wrap_c, c_out, c_sel, c_step, c_wrap);
      end
      n_vec++; if ({out_al, sel_al, step_al, wrap_al} !== {~e_out, e_sel, e_step, e_wrap}) begin
        n_err++; $display("FAIL rand_al: cyc %0d got %h/%0d want %h/%0d", c, out_al, sel_al, ~e_out, e_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_sweep();
    test_hold_disable();
    test_mode_switch();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
